pwr_fault_retry_ctrl: RTL and testbench
=======================================

Name: pwr_fault_retry_ctrl

Overview:
- Supervises the master power sequencer after it reaches S0, using the sequencer's fault flags.
- On a fault it latches a prioritized fault code and forces a DC power-off request into the sequencer's DC_PWR_BTN_ON path. After a cool-down it releases the request to auto-retry power-on.
- Escalates to a latched lockout after MAX_RETRY failed attempts.
- Sits between the sequencer fault outputs and the power-button/BMC logic. Runs from the 2 MHz system clock plus a 1 ms tick enable.

Parameters:
- MAX_RETRY, 3, number of automatic power-on retries before lockout (0..15).
- OFF_DLY_MS, 16'd5000, power-off hold time in 1 ms ticks before a retry.
- RECOVER_TO_MS, 16'd15000, maximum ticks allowed to regain S0 after a retry.
- STABLE_MS, 16'd60000, ticks of fault-free S0 after which the retry count clears.

Ports:
- iClk  in  1  module clock, 2 MHz.
- iRst_n  in  1  asynchronous active-low reset.
- iTick_1ms  in  1  single-iClk-cycle pulse every 1 ms, synchronous to iClk.
- iSeq_State  in  4  sequencer FSM state code; 4'h0 = S0.
- iFlt_N  in  6  active-low fault flags. Bit 0 AUX_SEQPWR, 1 N1N2_SEQPWR, 2 PERST_SEQPWR, 3 AUX_RUNTIME, 4 FAN_RUNTIME, 5 N1N2_RUNTIME.
- iClear_Fault  in  1  BMC clear request, level-sampled each iClk.
- oPwr_Off_Req  out  1  1 = force sequencer DC off.
- oLockout  out  1  1 = retries exhausted.
- oFault_Code  out  4  latched fault code; 0 = none.
- oRetry_Cnt  out  4  retries consumed.
- oState  out  3  FSM state, for debug.

Behaviour:
- One clock (iClk). Reset is asynchronous, active-low (iRst_n).
- Reset values:
  - oPwr_Off_Req = 0, oLockout = 0, oFault_Code = 0, oRetry_Cnt = 0, oState = IDLE.
  - Internal 16-bit tick counter = 0.
- Counter rules:
  - The counter clears on every state entry and increments only on cycles with iTick_1ms = 1.
  - It saturates at 16'hFFFF.
  - Expiry condition is counter >= limit, evaluated every iClk. A limit of 0 therefore expires on the first cycle in the state.
- Fault detect: fault = any iFlt_N bit == 0. When several bits are low, the lowest index wins: code = index + 1 (1..6). Code 4'hE = recovery timeout.
- States (oState encoding):
  - IDLE (0): oPwr_Off_Req = 0. When iSeq_State == 0, go to ARMED on the next cycle.
  - ARMED (1):
    - Fault: latch the code and set oPwr_Off_Req = 1 on the next edge, then go to OFF_WAIT.
    - Else, when the counter reaches STABLE_MS: clear oRetry_Cnt. oFault_Code is kept for the BMC.
  - OFF_WAIT (2):
    - oPwr_Off_Req = 1 and iFlt_N is ignored.
    - On expiry with oRetry_Cnt < MAX_RETRY: increment oRetry_Cnt, drop oPwr_Off_Req, go to RECOVER.
    - On expiry otherwise: go to LOCKOUT.
  - RECOVER (3):
    - iSeq_State == 0 with no fault: go to ARMED.
    - Fault seen: handled as in ARMED (new code latched, overwriting the old one).
    - Counter reaches RECOVER_TO_MS: code = 4'hE, oPwr_Off_Req = 1, go to OFF_WAIT.
  - LOCKOUT (4): oPwr_Off_Req = 1, oLockout = 1. Stays in LOCKOUT until iClear_Fault.
- iClear_Fault = 1 in any state:
  - Next edge: oFault_Code = 0, oRetry_Cnt = 0, oLockout = 0, oPwr_Off_Req = 0, state = IDLE.
  - It has priority over a simultaneous fault or counter expiry.
- RECOVER priority: a fault in the same cycle as the timeout takes the fault path. A fault in the same cycle as iSeq_State == 0 is treated as a fault.
- All outputs are registered. Fault-to-oPwr_Off_Req latency is exactly 1 iClk.
- Unused state codes 5..7 go to IDLE with all outputs at reset values.
- Reset mid-operation returns immediately to reset values. No fault history is retained across reset.

Test Plan:
1. Reset, iSeq_State = 0, iFlt_N = 6'h3F for 10 cycles -> oState = 1, oPwr_Off_Req = 0, oFault_Code = 0.
2. In ARMED, drive iFlt_N = 6'b110101 (bits 1 and 3 low) -> 1 cycle later oFault_Code = 2, oPwr_Off_Req = 1, oState = 2. After 5000 ticks: oRetry_Cnt = 1, oPwr_Off_Req = 0, oState = 3.
3. In RECOVER, hold iSeq_State = 4'h5 for 15000 ticks -> oFault_Code = 4'hE, oPwr_Off_Req = 1, oState = 2.
4. MAX_RETRY = 3 with the fault kept asserted through every RECOVER -> after the 4th OFF_WAIT expiry, oLockout = 1, oRetry_Cnt = 3, oPwr_Off_Req = 1. A 1-cycle iClear_Fault then gives all outputs 0, oState = 0.
5. Assert iClear_Fault in the same cycle as a fault in ARMED -> next cycle oState = 0, oFault_Code = 0, oPwr_Off_Req = 0.
6. After one retry, hold fault-free S0 for 60000 ticks -> oRetry_Cnt = 0, oFault_Code keeps its code. Assert iRst_n = 0 mid-OFF_WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pwr_fault_retry_ctrl.sv
// Power fault supervisor with auto-retry and lockout.
// Watches the sequencer once it reaches S0. On a fault it latches a
// prioritized fault code and holds a DC power-off request. After the off
// hold time it releases the request so the sequencer can retry power-on.
// After MAX_RETRY failed retries it latches a lockout until the BMC clears it.
module pwr_fault_retry_ctrl #(
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [15:0] OFF_DLY_MS    = 16'd5000,
  parameter logic [15:0] RECOVER_TO_MS = 16'd15000,
  parameter logic [15:0] STABLE_MS     = 16'd60000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iTick_1ms,
  input  logic [3:0] iSeq_State,
  input  logic [5:0] iFlt_N,
  input  logic       iClear_Fault,
  output logic       oPwr_Off_Req,
  output logic       oLockout,
  output logic [3:0] oFault_Code,
  output logic [3:0] oRetry_Cnt,
  output logic [2:0] oState
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_OFF_WAIT = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  localparam logic [3:0] MAX_RETRY_W   = 4'(MAX_RETRY);
  localparam logic [3:0] CODE_RECOV_TO = 4'hE;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        req_next, lock_next;
  logic [3:0]  code_next, retry_next;
  logic [3:0]  flt_code;
  logic        fault;
  logic        seq_s0;

  assign fault  = (iFlt_N != 6'h3F);
  assign seq_s0 = (iSeq_State == 4'h0);
  assign oState = state_reg;

  // Lowest-index active-low fault flag wins; code is index + 1.
  always_comb begin
    flt_code = 4'h0;
    for (int i = 5; i >= 0; i--) begin
      if (!iFlt_N[i]) flt_code = 4'(i + 1);
    end
  end

  // Next-state and next-output decisions; BMC clear overrides everything.
  always_comb begin
    state_next = state_reg;
    req_next   = oPwr_Off_Req;
    lock_next  = oLockout;
    code_next  = oFault_Code;
    retry_next = oRetry_Cnt;
    if (iClear_Fault) begin
      state_next = ST_IDLE;
      req_next   = 1'b0;
      lock_next  = 1'b0;
      code_next  = 4'h0;
      retry_next = 4'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_next = 1'b0;
          if (seq_s0) state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (fault) begin
            code_next  = flt_code;
            req_next   = 1'b1;
            state_next = ST_OFF_WAIT;
          end else if (cnt_reg >= STABLE_MS) begin
            retry_next = 4'h0;
          end
        end
        ST_OFF_WAIT: begin
          req_next = 1'b1;
          if (cnt_reg >= OFF_DLY_MS) begin
            if (oRetry_Cnt < MAX_RETRY_W) begin
              retry_next = oRetry_Cnt + 4'd1;
              req_next   = 1'b0;
              state_next = ST_RECOVER;
            end else begin
              lock_next  = 1'b1;
              state_next = ST_LOCKOUT;
            end
          end
        end
        ST_RECOVER: begin
          // A fault beats both a successful S0 and the recovery timeout.
          if (fault) begin
            code_next  = flt_code;
            req_next   = 1'b1;
            state_next = ST_OFF_WAIT;
          end else if (seq_s0) begin
            state_next = ST_ARMED;
          end else if (cnt_reg >= RECOVER_TO_MS) begin
            code_next  = CODE_RECOV_TO;
            req_next   = 1'b1;
            state_next = ST_OFF_WAIT;
          end
        end
        ST_LOCKOUT: begin
          req_next  = 1'b1;
          lock_next = 1'b1;
        end
        default: begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
          lock_next  = 1'b0;
          code_next  = 4'h0;
          retry_next = 4'h0;
        end
      endcase
    end
  end

  // Phase timer: restarts on every state change, counts ms ticks, saturates.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = 16'h0000;
    end else if (iTick_1ms && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 16'h0000;
      oPwr_Off_Req <= 1'b0;
      oLockout     <= 1'b0;
      oFault_Code  <= 4'h0;
      oRetry_Cnt   <= 4'h0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      oPwr_Off_Req <= req_next;
      oLockout     <= lock_next;
      oFault_Code  <= code_next;
      oRetry_Cnt   <= retry_next;
    end
  end

endmodule

// File: tb/tb_pwr_fault_retry_ctrl.sv
// Self-checking bench for pwr_fault_retry_ctrl: directed scenarios followed
// by randomized stimulus, all checked against a behavioural model.
module tb_pwr_fault_retry_ctrl;

  localparam int P_MAX_RETRY = 3;
  localparam int P_OFF       = 5;
  localparam int P_RTO       = 8;
  localparam int P_STB       = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] seq = 4'h0;
  logic [5:0] flt = 6'h3F;
  logic       req, lock;
  logic [3:0] code, retry;
  logic [2:0] st;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: phase number, elapsed ms in phase, and output values.
  int m_phase, m_ms, m_retry, m_code;
  int m_req, m_lock;

  always #5 clk = ~clk;

  pwr_fault_retry_ctrl #(
    .MAX_RETRY    (P_MAX_RETRY),
    .OFF_DLY_MS   (16'(P_OFF)),
    .RECOVER_TO_MS(16'(P_RTO)),
    .STABLE_MS    (16'(P_STB))
  ) dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iTick_1ms   (tick),
    .iSeq_State  (seq),
    .iFlt_N      (flt),
    .iClear_Fault(clr),
    .oPwr_Off_Req(req),
    .oLockout    (lock),
    .oFault_Code (code),
    .oRetry_Cnt  (retry),
    .oState      (st)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    cmp_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".state"}, int'(st), m_phase);
    check_val({ctx, ".req"},   int'(req), m_req);
    check_val({ctx, ".lock"},  int'(lock), m_lock);
    check_val({ctx, ".code"},  int'(code), m_code);
    check_val({ctx, ".retry"}, int'(retry), m_retry);
  endtask

  task automatic model_reset();
    m_phase = 0; m_ms = 0; m_retry = 0; m_code = 0; m_req = 0; m_lock = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs of that edge.
  task automatic model_step(input logic [3:0] s, input logic [5:0] f,
                            input logic t, input logic c);
    int fc, nph;
    fc = 0;
    for (int i = 0; i < 6; i++) begin
      if (f[i] == 1'b0) begin
        fc = i + 1;
        break;
      end
    end
    nph = m_phase;
    if (c) begin
      nph = 0; m_req = 0; m_lock = 0; m_code = 0; m_retry = 0;
    end else if (m_phase == 0) begin
      if (s == 0) nph = 1;
    end else if (m_phase == 1) begin
      if (fc != 0) begin
        m_code = fc; m_req = 1; nph = 2;
      end else if (m_ms >= P_STB) begin
        m_retry = 0;
      end
    end else if (m_phase == 2) begin
      if (m_ms >= P_OFF) begin
        if (m_retry < P_MAX_RETRY) begin
          m_retry++; m_req = 0; nph = 3;
        end else begin
          m_lock = 1; nph = 4;
        end
      end
    end else if (m_phase == 3) begin
      if (fc != 0) begin
        m_code = fc; m_req = 1; nph = 2;
      end else if (s == 0) begin
        nph = 1;
      end else if (m_ms >= P_RTO) begin
        m_code = 14; m_req = 1; nph = 2;
      end
    end
    if (nph != m_phase) m_ms = 0;
    else if (t && m_ms < 65535) m_ms++;
    m_phase = nph;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic [3:0] s, input logic [5:0] f,
                       input logic t, input logic c);
    seq = s; flt = f; tick = t; clr = c;
    @(posedge clk);
    #1;
    model_step(s, f, t, c);
    check_all("cyc");
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [3:0] rs;
    logic [5:0] rf;
    logic rt, rc;

    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 1: reach ARMED
    repeat (10) cycle(4'h0, 6'h3F, 1'b1, 1'b0);
    check_val("t1.state", int'(st), 1);
    check_val("t1.code", int'(code), 0);
    $display("scenario 1: armed, state=%0d", st);

    // 2: bits 1 and 3 low -> code 2, then OFF_WAIT hold
    cycle(4'h0, 6'b110101, 1'b1, 1'b0);
    check_val("t2.code", int'(code), 2);
    check_val("t2.req", int'(req), 1);
    check_val("t2.state", int'(st), 2);
    k = 0;
    while (st == 3'd2 && k < 40) begin
      cycle(4'h5, 6'h3F, 1'b1, 1'b0);
      k++;
    end
    check_val("t2.off_len", k, P_OFF + 1);
    check_val("t2.retry", int'(retry), 1);
    check_val("t2.req_drop", int'(req), 0);
    check_val("t2.recover", int'(st), 3);
    $display("scenario 2: fault code=%0d, off hold %0d cycles", code, k);

    // 3: recovery timeout
    k = 0;
    while (st == 3'd3 && k < 40) begin
      cycle(4'h5, 6'h3F, 1'b1, 1'b0);
      k++;
    end
    check_val("t3.rto_len", k, P_RTO + 1);
    check_val("t3.code", int'(code), 14);
    check_val("t3.req", int'(req), 1);
    check_val("t3.state", int'(st), 2);
    $display("scenario 3: recovery timeout after %0d cycles", k);

    // 4: persistent fault until lockout, then clear
    k = 0;
    while (!lock && k < 200) begin
      cycle(4'h5, 6'h3E, 1'b1, 1'b0);
      k++;
    end
    check_val("t4.lock", int'(lock), 1);
    check_val("t4.retry", int'(retry), 3);
    check_val("t4.req", int'(req), 1);
    check_val("t4.state", int'(st), 4);
    cycle(4'h5, 6'h3E, 1'b1, 1'b1);
    check_val("t4.clr_state", int'(st), 0);
    check_val("t4.clr_lock", int'(lock), 0);
    check_val("t4.clr_req", int'(req), 0);
    check_val("t4.clr_code", int'(code), 0);
    $display("scenario 4: lockout reached and cleared");

    // 5: clear wins over a simultaneous fault in ARMED
    cycle(4'h0, 6'h3F, 1'b0, 1'b0);
    check_val("t5.armed", int'(st), 1);
    cycle(4'h0, 6'h3B, 1'b1, 1'b1);
    check_val("t5.state", int'(st), 0);
    check_val("t5.code", int'(code), 0);
    check_val("t5.req", int'(req), 0);
    $display("scenario 5: clear priority over fault");

    // 6: stable S0 clears retry count, code is kept; reset mid OFF_WAIT
    cycle(4'h0, 6'h3F, 1'b1, 1'b0);
    cycle(4'h0, 6'h3E, 1'b1, 1'b0);
    k = 0;
    while (st == 3'd2 && k < 40) begin
      cycle(4'h5, 6'h3F, 1'b1, 1'b0);
      k++;
    end
    cycle(4'h0, 6'h3F, 1'b1, 1'b0);
    check_val("t6.retry1", int'(retry), 1);
    k = 0;
    while (retry != 4'd0 && k < 100) begin
      cycle(4'h0, 6'h3F, 1'b1, 1'b0);
      k++;
    end
    check_val("t6.stable_len", k, P_STB + 1);
    check_val("t6.retry0", int'(retry), 0);
    check_val("t6.code_kept", int'(code), 1);
    cycle(4'h0, 6'h3E, 1'b1, 1'b0);
    cycle(4'h5, 6'h3F, 1'b1, 1'b0);
    do_reset();
    $display("scenario 6: stable clear and async reset");

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rt = ($urandom_range(3) == 0);
      rs = ($urandom_range(3) != 0) ? 4'h0 : 4'($urandom_range(15));
      rf = ($urandom_range(30) == 0) ? 6'($urandom_range(63)) : 6'h3F;
      rc = ($urandom_range(400) == 0);
      if ($urandom_range(1500) == 0) do_reset();
      else cycle(rs, rf, rt, rc);
      if (n % 500 == 499)
        $display("random burst to %0d: state=%0d retry=%0d code=%0d", n + 1, st, retry, code);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
